// File: rtl/de1_button_conditioner.sv
// de1_button_conditioner
// Synchronises and debounces WIDTH push-button pins against a shared
// millisecond time base. Each channel gets a level and one-cycle press and
// release strobes. One selected channel also drives a stretched active-high
// reset for downstream logic.
module de1_button_conditioner #(
   parameter int CLK_HZ      = 50000000,
   parameter int DEBOUNCE_MS = 5,
   parameter int PULSE_CLK   = 7,
   parameter int WIDTH       = 4,
   parameter int ACTIVE_LOW  = 1,
   parameter int RST_CH      = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn_pin,
   output logic [WIDTH-1:0] btn_state,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release,
   output logic             ms_tick,
   output logic             rst_out
);

   localparam int DIV   = CLK_HZ / 1000;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
   localparam int PW_W  = (PULSE_CLK > 0) ? $clog2(PULSE_CLK + 1) : 1;

   // XOR mask that turns the synchronised pin level into "1 = pressed".
   localparam logic [WIDTH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   // Reject parameter sets the counters below cannot represent.
   if (DIV < 2) begin : g_bad_div
      $error("de1_button_conditioner: CLK_HZ/1000 must be at least 2");
   end
   if (DEBOUNCE_MS < 1) begin : g_bad_debounce
      $error("de1_button_conditioner: DEBOUNCE_MS must be at least 1");
   end
   if (PULSE_CLK < 1) begin : g_bad_pulse
      $error("de1_button_conditioner: PULSE_CLK must be at least 1");
   end
   if (RST_CH < 0 || RST_CH >= WIDTH) begin : g_bad_rst_ch
      $error("de1_button_conditioner: RST_CH must index an existing channel");
   end

   logic [PRE_W-1:0] pre;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] s;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [PW_W-1:0]  pw;

   // Millisecond prescaler; ms_tick is registered so it lands one cycle after pre wraps.
   // NOTE: every sequential block uses non-blocking assignments so all flops
   // sample the pre-edge values and simulation matches the synthesised netlist.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre     <= '0;
         ms_tick <= 1'b0;
      end else begin
         ms_tick <= (pre == PRE_W'(DIV - 1));
         pre     <= (pre == PRE_W'(DIV - 1)) ? '0 : pre + 1'b1;
      end
   end

   // Two-flop synchroniser bringing the asynchronous pins into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_pin;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ POL_MASK;

   // Per-channel debounce: a disagreement must survive DEBOUNCE_MS ticks in a row.
   // NOTE: the counter array is small and built from flops, so it is reset
   // like any other register; a discarded debounce must restart from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_state   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == btn_state[i]) begin
               // Any agreement, even on a tick cycle, restarts the count.
               cnt[i] <= '0;
            end else if (ms_tick && cnt[i] == CNT_W'(DEBOUNCE_MS - 1)) begin
               btn_state[i]   <= s[i];
               btn_press[i]   <= s[i];
               btn_release[i] <= ~s[i];
               cnt[i]         <= '0;
            end else if (ms_tick) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Reset stretcher: held while the reset button is down, then PULSE_CLK more clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pw      <= PW_W'(PULSE_CLK);
         rst_out <= 1'b1;
      end else if (btn_state[RST_CH]) begin
         pw      <= PW_W'(PULSE_CLK);
         rst_out <= 1'b1;
      end else if (pw != '0) begin
         pw      <= pw - 1'b1;
         rst_out <= 1'b1;
      end else begin
         rst_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_de1_button_conditioner.sv
// Directed bench for de1_button_conditioner at DIV=10, DEBOUNCE_MS=3,
// PULSE_CLK=7, WIDTH=4, active-low pins, reset driven by channel 0.
module tb_de1_button_conditioner;

   localparam int CLK_HZ      = 10000;
   localparam int DEBOUNCE_MS = 3;
   localparam int PULSE_CLK   = 7;
   localparam int WIDTH       = 4;
   localparam int ACTIVE_LOW  = 1;
   localparam int RST_CH      = 0;

   // Debounce latency window in clocks, from the pin change.
   localparam int LAT_MIN = 23;
   localparam int LAT_MAX = 32;
   localparam int BOUND   = 60;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] btn_pin;
   logic [WIDTH-1:0] btn_state;
   logic [WIDTH-1:0] btn_press;
   logic [WIDTH-1:0] btn_release;
   logic             ms_tick;
   logic             rst_out;

   int vectors     = 0;
   int miscompares = 0;
   int press_cnt   [WIDTH];
   int release_cnt [WIDTH];
   int both_cnt    = 0;

   de1_button_conditioner #(
      .CLK_HZ     (CLK_HZ),
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .PULSE_CLK  (PULSE_CLK),
      .WIDTH      (WIDTH),
      .ACTIVE_LOW (ACTIVE_LOW),
      .RST_CH     (RST_CH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_pin    (btn_pin),
      .btn_state  (btn_state),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .ms_tick    (ms_tick),
      .rst_out    (rst_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts clocks until btn_state[ch] reaches val; gives up at BOUND.
   task automatic wait_state(input int ch, input logic val, output int d);
      d = 0;
      do begin
         @(negedge clk);
         d++;
      end while (btn_state[ch] !== val && d < BOUND);
   endtask

   // Strobe bookkeeping, sampled away from the active edge.
   initial begin
      for (int i = 0; i < WIDTH; i++) begin
         press_cnt[i]   = 0;
         release_cnt[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (btn_press[i] === 1'b1)   press_cnt[i]++;
         if (btn_release[i] === 1'b1) release_cnt[i]++;
         if (btn_press[i] === 1'b1 && btn_release[i] === 1'b1) both_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d;

      // 1: reset values and release behaviour, all pins idle high.
      rst     = 1'b1;
      btn_pin = 4'hF;
      cycles(3);
      check("rst_rst_out", rst_out, 1);
      check("rst_state", btn_state, 4'h0);
      check("rst_press", btn_press, 4'h0);
      check("rst_release", btn_release, 4'h0);
      check("rst_tick", ms_tick, 0);
      rst = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         @(negedge clk);
         check($sformatf("rel_rst_out_e%0d", e), rst_out, (e < 8) ? 1 : 0);
         check($sformatf("rel_tick_e%0d", e), ms_tick, (e % 10 == 0) ? 1 : 0);
      end
      check("idle_state", btn_state, 4'h0);

      // 2: clean press and release on pin 2.
      btn_pin[2] = 1'b0;
      wait_state(2, 1'b1, d);
      check("p2_press_lat", (d >= LAT_MIN && d <= LAT_MAX), 1);
      check("p2_press_strobe", btn_press, 4'b0100);
      check("p2_press_state", btn_state, 4'b0100);
      check("p2_press_no_rel", btn_release, 4'h0);
      @(negedge clk);
      check("p2_press_1clk", btn_press, 4'h0);
      check("p2_rst_out_idle", rst_out, 0);
      cycles(10);
      btn_pin[2] = 1'b1;
      wait_state(2, 1'b0, d);
      check("p2_rel_lat", (d >= LAT_MIN && d <= LAT_MAX), 1);
      check("p2_rel_strobe", btn_release, 4'b0100);
      check("p2_rel_no_press", btn_press, 4'h0);
      @(negedge clk);
      check("p2_rel_1clk", btn_release, 4'h0);

      // 3: short glitch, then bounce settling low on pin 1.
      btn_pin[1] = 1'b0;
      cycles(15);
      btn_pin[1] = 1'b1;
      cycles(50);
      check("glitch_state", btn_state[1], 0);
      check("glitch_press_cnt", press_cnt[1], 0);
      for (int k = 0; k < 20; k++) begin
         btn_pin[1] = (k % 2 == 1) ? 1'b1 : 1'b0;
         cycles(5);
      end
      check("bounce_no_state", btn_state[1], 0);
      btn_pin[1] = 1'b0;
      cycles(40);
      check("bounce_state", btn_state[1], 1);
      check("bounce_press_cnt", press_cnt[1], 1);
      btn_pin[1] = 1'b1;
      cycles(40);
      check("bounce_rel_state", btn_state[1], 0);
      check("bounce_rel_cnt", release_cnt[1], 1);

      // 4: reset channel held for 50 ms, then released.
      btn_pin[0] = 1'b0;
      wait_state(0, 1'b1, d);
      check("ch0_press_lat", (d >= LAT_MIN && d <= LAT_MAX), 1);
      check("ch0_rst_out_same_edge", rst_out, 0);
      @(negedge clk);
      check("ch0_rst_out_rise", rst_out, 1);
      cycles(500);
      check("ch0_rst_out_held", rst_out, 1);
      btn_pin[0] = 1'b1;
      wait_state(0, 1'b0, d);
      check("ch0_rel_lat", (d >= LAT_MIN && d <= LAT_MAX), 1);
      check("ch0_rst_out_at_rel", rst_out, 1);
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         check($sformatf("ch0_stretch_j%0d", j), rst_out, (j < 8) ? 1 : 0);
      end

      // 5: pins 1 and 3 change together.
      btn_pin[1] = 1'b0;
      btn_pin[3] = 1'b0;
      wait_state(1, 1'b1, d);
      check("sim_press_lat", (d >= LAT_MIN && d <= LAT_MAX), 1);
      check("sim_press_strobe", btn_press, 4'b1010);
      check("sim_press_state", btn_state, 4'b1010);
      cycles(5);
      btn_pin[1] = 1'b1;
      btn_pin[3] = 1'b1;
      wait_state(1, 1'b0, d);
      check("sim_rel_strobe", btn_release, 4'b1010);
      check("sim_rel_state", btn_state, 4'b0000);

      // 6: reset asserted 20 clocks into a press on pin 2.
      cycles(5);
      btn_pin[2] = 1'b0;
      cycles(20);
      check("mid_pre_state", btn_state, 4'h0);
      check("mid_pre_rst_out", rst_out, 0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_async", rst_out, 1);
      check("mid_state_rst", btn_state, 4'h0);
      check("mid_press_rst", btn_press, 4'h0);
      check("mid_tick_rst", ms_tick, 0);
      cycles(2);
      rst = 1'b0;
      d = 0;
      do begin
         @(negedge clk);
         d++;
      end while (btn_press[2] !== 1'b1 && d < BOUND);
      check("mid_press_lat", (d >= LAT_MIN && d <= LAT_MAX), 1);
      check("mid_press_state", btn_state, 4'b0100);
      check("mid_rst_out_done", rst_out, 0);

      // Whole-run strobe totals.
      @(negedge clk);
      check("tot_press0", press_cnt[0], 1);
      check("tot_press1", press_cnt[1], 2);
      check("tot_press2", press_cnt[2], 2);
      check("tot_press3", press_cnt[3], 1);
      check("tot_rel2", release_cnt[2], 1);
      check("tot_both", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
